// File: rtl/keypad_scanner.sv
// keypad_scanner: scans and debounces a 4x4 active-low keypad into one-shot command codes.
// A NOP code (4'hD) sits on cmd between accepted presses.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       key_held
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] NOP = 4'hD;
  // Codes indexed by {row,col}, entry 0 in the low nibble.
  localparam logic [63:0] KEY_MAP = 64'hDE0F_C987_B654_A321;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
  state_t state_q, state_d;
  logic [3:0] s1_q, s2_q;
  logic [DW-1:0] div_q;
  logic [1:0] col_q;
  logic [15:0] snap_q, snap_d;
  logic [3:0] cand_q, cand_d, cnt_q, cnt_d, cmd_q, cmd_d;
  logic valid_q, valid_d;
  logic last, scan_done;
  logic [4:0] ones;
  logic [3:0] key, key_code;
  assign last      = div_q == DW'(SCAN_DIV - 1);
  assign scan_done = last && col_q == 2'd3;
  assign col_out   = ~(4'b0001 << col_q);
  assign cmd       = cmd_q;
  assign cmd_valid = valid_q;
  assign key_held  = state_q == HELD || state_q == RELEASE;
  assign key_code  = KEY_MAP[{key[1:0], key[3:2]} * 4 +: 4];
  always_comb begin
    snap_d = snap_q;
    if (last) snap_d[{col_q, 2'b00} +: 4] = ~s2_q;
  end
  // Classification sees the column-3 sample taken on the scan_done cycle itself.
  always_comb begin
    ones = '0;
    key  = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_d[i]) begin
        ones = ones + 5'd1;
        key  = 4'(i);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    cmd_d   = NOP;
    valid_d = 1'b0;
    if (scan_done) begin
      case (state_q)
        IDLE: if (ones == 5'd1) begin
          cand_d  = key;
          cnt_d   = 4'd1;
          state_d = DEBOUNCE;
        end
        DEBOUNCE: if (ones == 5'd1 && key == cand_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(DEBOUNCE_SCANS)) begin
            state_d = HELD;
            cmd_d   = key_code;
            valid_d = key_code != NOP;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        HELD: if (ones == 5'd0) begin
          cnt_d   = 4'd1;
          state_d = RELEASE;
        end
        RELEASE: if (ones == 5'd0) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(DEBOUNCE_SCANS)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else state_d = HELD;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q    <= 4'hF;
      s2_q    <= 4'hF;
      div_q   <= '0;
      col_q   <= '0;
      snap_q  <= '0;
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      cmd_q   <= NOP;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= row_in;
      s2_q    <= s1_q;
      div_q   <= last ? '0 : div_q + 1'b1;
      col_q   <= last ? col_q + 2'd1 : col_q;
      snap_q  <= snap_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed plus randomized keypad presses checked cycle by cycle
// against a per-scan debounce reference model.
module tb_keypad_scanner;
  localparam int SD  = 4;
  localparam int DEB = 3;
  logic clock = 1'b0, reset = 1'b1;
  logic [3:0] row_in, col_out, cmd;
  logic cmd_valid, key_held;
  logic [15:0] keys = '0;
  int checks = 0, failures = 0;
  bit m_hold = 1'b0;
  int m_run = 0, m_cand = 0;
  logic [3:0] code_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hF, 4'h0, 4'hE, 4'hD};

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
    .clock(clock), .reset(reset), .row_in(row_in), .col_out(col_out),
    .cmd(cmd), .cmd_valid(cmd_valid), .key_held(key_held)
  );

  always #5 clock = ~clock;

  // Physical matrix: a row reads low if any driven column has a pressed key on it.
  always_comb
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(~col_out & {keys[12+r], keys[8+r], keys[4+r], keys[r]});

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_scan(input logic [15:0] snap, output bit emit, output logic [3:0] code);
    int n, k;
    n = $countones(snap);
    k = 0;
    for (int i = 0; i < 16; i++) if (snap[i]) k = i;
    emit = 1'b0;
    code = code_tbl[(k % 4) * 4 + k / 4];
    if (!m_hold) begin
      if (n == 1 && m_run > 0 && k == m_cand) m_run++;
      else if (m_run > 0) m_run = 0;
      else if (n == 1) begin m_cand = k; m_run = 1; end
      if (m_run == DEB) begin
        m_hold = 1'b1;
        m_run  = 0;
        emit   = code != 4'hD;
      end
    end else begin
      m_run = (n == 0) ? m_run + 1 : 0;
      if (m_run == DEB) begin m_hold = 1'b0; m_run = 0; end
    end
  endtask

  task automatic do_scan(input logic [15:0] k);
    bit hp, em;
    logic [3:0] c, ec, ecmd;
    keys = k;
    hp = m_hold;
    model_scan(k, em, c);
    for (int j = 1; j <= 16; j++) begin
      @(posedge clock); #1;
      ec   = ~(4'b0001 << ((j / 4) % 4));
      ecmd = (j == 16 && em) ? c : 4'hD;
      chk("col_out", col_out, ec);
      chk("col_one_low", 8'($countones(~col_out)), 8'd1);
      chk("cmd", cmd, ecmd);
      chk("cmd_valid", cmd_valid, j == 16 && em);
      chk("key_held", key_held, (j == 16) ? m_hold : hp);
    end
  endtask

  task automatic reset_checks();
    chk("rst_col", col_out, 4'b1110);
    chk("rst_cmd", cmd, 4'hD);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1;
    #1 reset_checks();
    repeat (2) @(posedge clock);
    #1 reset_checks();
    @(negedge clock);
    reset = 1'b0;
    #1 reset_checks();
    m_hold = 1'b0;
    m_run  = 0;
  endtask

  task automatic hold(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) do_scan(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;
    int a, b;
    reset_dut();
    hold(16'h0020, 10);
    hold(16'h0000, 4);
    hold(16'h1000, 4);
    hold(16'h0000, 3);
    hold(16'h1000, 4);
    hold(16'h0000, 4);
    for (int i = 0; i < 10; i++) do_scan(i[0] ? 16'h0000 : 16'h0004);
    hold(16'h0081, 4);
    hold(16'h0001, 4);
    hold(16'h0000, 4);
    hold(16'h8000, 10);
    hold(16'h0000, 4);
    hold(16'h0008, 4);
    hold(16'h0000, 4);
    hold(16'h0800, 4);
    reset_dut();
    hold(16'h0800, 4);
    hold(16'h0000, 4);
    for (int s = 0; s < 40; s++) begin
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case ($urandom_range(0, 3))
        0:       pat = '0;
        3:       pat = (16'h1 << a) | (16'h1 << b);
        default: pat = 16'h1 << a;
      endcase
      hold(pat, $urandom_range(1, 5));
    end
    hold(16'h0000, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
